riscv_hwloop_regs: RTL and testbench

//  Hardware-loop register file for the RI5CY ID stage: holds start address, end address and iteration

---
 rtl/riscv_hwlp_pkg.sv | 23 ++
 rtl/riscv_hwloop_slot.sv | 62 ++++++
 rtl/riscv_hwloop_regs.sv | 57 +++++
 tb/tb_riscv_hwloop_regs.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_hwlp_pkg.sv
// Shared definitions for the RI5CY hardware-loop register file.
package riscv_hwlp_pkg;

    // Bit positions inside the 3-bit hwlp write-enable vector
    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    // Default number of hardware loop sets
    localparam int HWLP_N_REGS = 2;

    // Loop addresses are halfword aligned, so bit 0 is always forced low
    localparam logic [31:0] HWLP_ADDR_MASK = 32'hFFFF_FFFE;

    typedef logic [31:0] hwlp_addr_t;

    // Per-loop counter state: IDLE while the counter is zero, ARMED otherwise
    typedef enum logic {
        HWLP_IDLE  = 1'b0,
        HWLP_ARMED = 1'b1
    } hwlp_state_e;

endpackage

// File: rtl/riscv_hwloop_slot.sv
// One hardware-loop set: start/end address, iteration counter and active flag.
// A counter write always beats a same-cycle decrement; the counter saturates at zero.
module riscv_hwloop_slot
    import riscv_hwlp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_we_start,
    input  logic       i_we_end,
    input  logic       i_we_cnt,
    input  logic       i_dec,
    input  hwlp_addr_t i_start_data,
    input  hwlp_addr_t i_end_data,
    input  logic [31:0] i_cnt_data,
    output hwlp_addr_t o_start_addr,
    output hwlp_addr_t o_end_addr,
    output logic [31:0] o_counter,
    output logic       o_active
);

    hwlp_addr_t  r_start;
    hwlp_addr_t  r_end;
    logic [31:0] r_cnt;
    hwlp_state_e r_state;

    logic [31:0] w_cnt_next;

    // Next counter value: write has priority, decrement stops at zero
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_we_cnt) begin
            w_cnt_next = i_cnt_data;
        end else if (i_dec && (r_cnt != 32'd0)) begin
            w_cnt_next = r_cnt - 32'd1;
        end
    end

    // Loop-set registers and the IDLE/ARMED state, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start <= '0;
            r_end   <= '0;
            r_cnt   <= '0;
            r_state <= HWLP_IDLE;
        end else begin
            if (i_we_start) begin
                r_start <= i_start_data & HWLP_ADDR_MASK;
            end
            if (i_we_end) begin
                r_end <= i_end_data & HWLP_ADDR_MASK;
            end
            r_cnt   <= w_cnt_next;
            r_state <= (w_cnt_next != 32'd0) ? HWLP_ARMED : HWLP_IDLE;
        end
    end

    assign o_start_addr = r_start;
    assign o_end_addr   = r_end;
    assign o_counter    = r_cnt;
    assign o_active     = (r_state == HWLP_ARMED);

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file for the ID stage. Decodes the loop-select index
// into per-slot write enables and qualifies all writes and decrements with valid_i.
module riscv_hwloop_regs
    import riscv_hwlp_pkg::*;
#(
    parameter int N_REGS     = HWLP_N_REGS,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   hwlp_start_data_i,
    input  logic [31:0]                   hwlp_end_data_i,
    input  logic [31:0]                   hwlp_cnt_data_i,
    input  logic [2:0]                    hwlp_we_i,
    input  logic [N_REG_BITS-1:0]         hwlp_regid_i,
    input  logic                          valid_i,
    input  logic [N_REGS-1:0]             hwlp_dec_cnt_i,
    output logic [N_REGS-1:0][31:0]       hwlp_start_addr_o,
    output logic [N_REGS-1:0][31:0]       hwlp_end_addr_o,
    output logic [N_REGS-1:0][31:0]       hwlp_counter_o,
    output logic [N_REGS-1:0]             hwlp_active_o
);

    logic [31:0] w_regid;
    logic        w_regid_ok;

    assign w_regid    = 32'(hwlp_regid_i);
    assign w_regid_ok = (w_regid < 32'(N_REGS));

    for (genvar i = 0; i < N_REGS; i++) begin : g_slot
        localparam logic [31:0] SLOT_ID = 32'(i);

        logic w_sel;
        logic w_dec;

        // A slot is written only when selected by an in-range index on a valid ID cycle
        assign w_sel = valid_i && w_regid_ok && (w_regid == SLOT_ID);
        assign w_dec = valid_i && hwlp_dec_cnt_i[i];

        riscv_hwloop_slot u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_we_start   (w_sel && hwlp_we_i[HWLP_WE_START]),
            .i_we_end     (w_sel && hwlp_we_i[HWLP_WE_END]),
            .i_we_cnt     (w_sel && hwlp_we_i[HWLP_WE_CNT]),
            .i_dec        (w_dec),
            .i_start_data (hwlp_start_data_i),
            .i_end_data   (hwlp_end_data_i),
            .i_cnt_data   (hwlp_cnt_data_i),
            .o_start_addr (hwlp_start_addr_o[i]),
            .o_end_addr   (hwlp_end_addr_o[i]),
            .o_counter    (hwlp_counter_o[i]),
            .o_active     (hwlp_active_o[i])
        );
    end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Directed bench for the hardware-loop register file, with a 2-loop and a 3-loop instance.
module tb_riscv_hwloop_regs;

   logic        clk;
   logic        rst_n;
   logic [31:0] startData;
   logic [31:0] endData;
   logic [31:0] cntData;
   logic [2:0]  we;
   logic        regId;
   logic        valid;
   logic [1:0]  decCnt;
   logic [1:0][31:0] startAddr;
   logic [1:0][31:0] endAddr;
   logic [1:0][31:0] counter;
   logic [1:0]  active;

   logic [2:0]  we3;
   logic [1:0]  regId3;
   logic [2:0]  decCnt3;
   logic [2:0][31:0] startAddr3;
   logic [2:0][31:0] endAddr3;
   logic [2:0][31:0] counter3;
   logic [2:0]  active3;

   int assertCount = 0;
   int failCount   = 0;

   riscv_hwloop_regs #(.N_REGS(2), .N_REG_BITS(1)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .hwlp_start_data_i (startData),
      .hwlp_end_data_i   (endData),
      .hwlp_cnt_data_i   (cntData),
      .hwlp_we_i         (we),
      .hwlp_regid_i      (regId),
      .valid_i           (valid),
      .hwlp_dec_cnt_i    (decCnt),
      .hwlp_start_addr_o (startAddr),
      .hwlp_end_addr_o   (endAddr),
      .hwlp_counter_o    (counter),
      .hwlp_active_o     (active)
   );

   riscv_hwloop_regs #(.N_REGS(3), .N_REG_BITS(2)) dut3 (
      .clk               (clk),
      .rst_n             (rst_n),
      .hwlp_start_data_i (startData),
      .hwlp_end_data_i   (endData),
      .hwlp_cnt_data_i   (cntData),
      .hwlp_we_i         (we3),
      .hwlp_regid_i      (regId3),
      .valid_i           (valid),
      .hwlp_dec_cnt_i    (decCnt3),
      .hwlp_start_addr_o (startAddr3),
      .hwlp_end_addr_o   (endAddr3),
      .hwlp_counter_o    (counter3),
      .hwlp_active_o     (active3)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus, then sample 1 ns after the rising edge
   task automatic applyStimulus(input logic [2:0] weIn, input logic regIn,
                                input logic [31:0] s, input logic [31:0] e,
                                input logic [31:0] c, input logic v, input logic [1:0] d);
      we        = weIn;
      regId     = regIn;
      startData = s;
      endData   = e;
      cntData   = c;
      valid     = v;
      decCnt    = d;
      @(posedge clk);
      #1;
      we     = 3'b000;
      decCnt = 2'b00;
   endtask

   // One counted comparison; failures are reported and counted, never fatal
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Directed sequence: reset, writes, decrements, priority and out-of-range index
   initial begin
      rst_n = 1'b0; we = 3'b000; regId = 1'b0; valid = 1'b0; decCnt = 2'b00;
      startData = '0; endData = '0; cntData = '0;
      we3 = 3'b000; regId3 = 2'd0; decCnt3 = 3'b000;

      // Reset with a counter write pending: reset wins
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd5, 1'b1, 2'b00);
      checkOutput("rst_cnt0",   counter[0],   32'd0);
      checkOutput("rst_cnt1",   counter[1],   32'd0);
      checkOutput("rst_start0", startAddr[0], 32'd0);
      checkOutput("rst_end1",   endAddr[1],   32'd0);
      checkOutput("rst_active", {30'd0, active}, 32'd0);
      checkOutput("rst_cnt3_2", counter3[2],  32'd0);
      rst_n = 1'b1;

      // Full write to loop 1, end address alignment
      applyStimulus(3'b111, 1'b1, 32'h100, 32'h121, 32'd3, 1'b1, 2'b00);
      checkOutput("wr1_start", startAddr[1], 32'h100);
      checkOutput("wr1_end",   endAddr[1],   32'h120);
      checkOutput("wr1_cnt",   counter[1],   32'd3);
      checkOutput("wr1_active", {30'd0, active}, 32'h2);
      checkOutput("wr1_cnt0",  counter[0],   32'd0);
      checkOutput("wr1_start0", startAddr[0], 32'd0);

      // Loop 0 counts down from 2 and saturates at zero
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd2, 1'b1, 2'b00);
      checkOutput("dn_cnt_init", counter[0], 32'd2);
      checkOutput("dn_act_init", {30'd0, active}, 32'h3);
      applyStimulus(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01);
      checkOutput("dn_cnt_1", counter[0], 32'd1);
      checkOutput("dn_act_1", {30'd0, active}, 32'h3);
      applyStimulus(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01);
      checkOutput("dn_cnt_0", counter[0], 32'd0);
      checkOutput("dn_act_0", {30'd0, active}, 32'h2);
      applyStimulus(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b01);
      checkOutput("dn_cnt_sat", counter[0], 32'd0);
      checkOutput("dn_act_sat", {30'd0, active}, 32'h2);
      checkOutput("dn_cnt1_kept", counter[1], 32'd3);

      // Decrement and write are ignored while valid_i is low
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd6, 1'b1, 2'b00);
      checkOutput("nv_cnt_init", counter[0], 32'd6);
      applyStimulus(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b0, 2'b01);
      checkOutput("nv_dec", counter[0], 32'd6);
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd7, 1'b0, 2'b00);
      checkOutput("nv_wr", counter[0], 32'd6);

      // Counter write beats a same-cycle decrement
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd5, 1'b1, 2'b00);
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd9, 1'b1, 2'b01);
      checkOutput("prio_cnt_wr", counter[0], 32'd9);

      // Start-only write leaves a same-cycle decrement in effect
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd5, 1'b1, 2'b00);
      applyStimulus(3'b001, 1'b0, 32'h203, 32'h0, 32'd9, 1'b1, 2'b01);
      checkOutput("prio_start_cnt", counter[0],   32'd4);
      checkOutput("prio_start_adr", startAddr[0], 32'h202);
      checkOutput("prio_end_kept",  endAddr[0],   32'd0);

      // Parallel decrements on both loops
      applyStimulus(3'b100, 1'b0, 32'h0, 32'h0, 32'd4, 1'b1, 2'b00);
      applyStimulus(3'b100, 1'b1, 32'h0, 32'h0, 32'd7, 1'b1, 2'b00);
      applyStimulus(3'b000, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1, 2'b11);
      checkOutput("par_cnt0", counter[0], 32'd3);
      checkOutput("par_cnt1", counter[1], 32'd6);
      checkOutput("par_act", {30'd0, active}, 32'h3);

      // Counter write of zero disarms the loop
      applyStimulus(3'b100, 1'b1, 32'h0, 32'h0, 32'd0, 1'b1, 2'b00);
      checkOutput("zero_cnt1", counter[1], 32'd0);
      checkOutput("zero_act", {30'd0, active}, 32'h1);

      // Three-loop instance: valid write to slot 2, then out-of-range index 3
      we3 = 3'b111; regId3 = 2'd2;
      startData = 32'h41; endData = 32'h81; cntData = 32'd2; valid = 1'b1;
      @(posedge clk);
      #1;
      we3 = 3'b000;
      checkOutput("n3_start2", startAddr3[2], 32'h40);
      checkOutput("n3_end2",   endAddr3[2],   32'h80);
      checkOutput("n3_cnt2",   counter3[2],   32'd2);
      we3 = 3'b111; regId3 = 2'd3;
      startData = 32'h555; endData = 32'h777; cntData = 32'd9; valid = 1'b1;
      @(posedge clk);
      #1;
      we3 = 3'b000;
      checkOutput("oor_cnt0",   counter3[0],   32'd0);
      checkOutput("oor_cnt1",   counter3[1],   32'd0);
      checkOutput("oor_cnt2",   counter3[2],   32'd2);
      checkOutput("oor_start2", startAddr3[2], 32'h40);
      checkOutput("oor_end0",   endAddr3[0],   32'd0);
      checkOutput("oor_act",    {29'd0, active3}, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
